imem_loader: RTL and testbench

//   Byte-stream program loader: the writer side of the core's instruction memory.

---
 rtl/imem_loader.sv | 197 +++++++++++++++++++
 tb/tb_imem_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream program loader: receives a word count, little-endian words and an
// XOR checksum over a valid/ready byte link, writes each completed word into the
// instruction memory and releases the core from reset only after a clean load.
module imem_loader #(
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error
);

    // Word counters need one extra bit so a full-depth count (N == DEPTH) fits.
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [CNT_W-1:0] n_words_q;
    logic [CNT_W-1:0] word_idx_q;
    logic [1:0]       byte_idx_q;
    logic [23:0]      shift_q;
    logic [7:0]       csum_q;

    logic             accept_c;
    logic             idle_like_c;
    logic             load_start_c;
    logic             last_byte_c;
    logic             last_word_c;
    logic             count_too_big_c;

    logic             in_ready_d;
    logic             wr_en_d;
    logic             cpu_rst_d;
    logic             busy_d;
    logic             done_d;
    logic             error_d;

    // Handshake and decode helpers shared by the next-state and datapath logic.
    always_comb begin
        accept_c        = in_valid && in_ready;
        idle_like_c     = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
        load_start_c    = start && idle_like_c;
        last_byte_c     = (byte_idx_q == 2'd3);
        last_word_c     = ((word_idx_q + CNT_W'(1)) == n_words_q);
        count_too_big_c = (32'(in_data) > DEPTH);
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: walk count, data words and checksum; start only when idle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (accept_c) begin
                    if (count_too_big_c) begin
                        state_d = S_ERROR;
                    end else if (in_data == 8'd0) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept_c && last_byte_c && last_word_c) begin
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (accept_c) begin
                    state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, decoded from the next state.
    always_comb begin
        in_ready_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        error_d    = 1'b0;
        cpu_rst_d  = 1'b0;
        wr_en_d    = 1'b0;
        unique case (state_d)
            S_COUNT, S_DATA, S_CHECK: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            S_DONE: begin
                done_d    = 1'b1;
                cpu_rst_d = 1'b1;
            end
            S_ERROR: begin
                error_d = 1'b1;
            end
            default: begin
                in_ready_d = 1'b0;
            end
        endcase
        if ((state_q == S_DATA) && accept_c && last_byte_c) begin
            wr_en_d = 1'b1;
        end
    end

    // Output registers and datapath: byte assembly, word index, running checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            cpu_rst    <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            n_words_q  <= '0;
            word_idx_q <= '0;
            byte_idx_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
        end else begin
            in_ready <= in_ready_d;
            busy     <= busy_d;
            done     <= done_d;
            error    <= error_d;
            cpu_rst  <= cpu_rst_d;
            wr_en    <= wr_en_d;
            if (load_start_c) begin
                n_words_q  <= '0;
                word_idx_q <= '0;
                byte_idx_q <= '0;
                shift_q    <= '0;
                csum_q     <= '0;
            end else if (accept_c) begin
                unique case (state_q)
                    S_COUNT: begin
                        n_words_q <= CNT_W'(in_data);
                        csum_q    <= csum_q ^ in_data;
                    end
                    S_DATA: begin
                        csum_q     <= csum_q ^ in_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        if (last_byte_c) begin
                            wr_addr    <= word_idx_q[ADDR_W-1:0];
                            wr_data    <= {in_data, shift_q};
                            word_idx_q <= word_idx_q + CNT_W'(1);
                        end else begin
                            // Bytes enter at the top so b0 ends up in the low byte.
                            shift_q <= {in_data, shift_q[23:8]};
                        end
                    end
                    default: begin
                        csum_q <= csum_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed loads from the block description plus randomized
// loads, all checked against a stream-level reference model of the loader.
module tb_imem_loader;

    typedef logic [7:0] u8_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        error;

    int n_cmp = 0;
    int n_bad = 0;

    u8_t         stim[$];
    logic [4:0]  log_addr[$];
    logic [31:0] log_data[$];
    logic [31:0] dut_mem[32];
    logic [31:0] exp_mem[32];
    logic [4:0]  exp_wa[$];
    logic [31:0] exp_wd[$];
    logic        exp_ok;

    imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .cpu_rst  (cpu_rst),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every write the loader issues into a bench-side memory image.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
            dut_mem[wr_addr] = wr_data;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_busy, input logic e_rdy,
                            input logic e_done, input logic e_err, input logic e_cpu);
        chk({tag, ".busy"},     32'(busy),     32'(e_busy));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(e_rdy));
        chk({tag, ".done"},     32'(done),     32'(e_done));
        chk({tag, ".error"},    32'(error),    32'(e_err));
        chk({tag, ".cpu_rst"},  32'(cpu_rst),  32'(e_cpu));
    endtask

    // Reference model: decode the stream format directly into writes and a verdict.
    task automatic model_load();
        int  n;
        u8_t ck;
        exp_wa.delete();
        exp_wd.delete();
        n = int'(stim[0]);
        if (n > 32) begin
            exp_ok = 1'b0;
        end else begin
            ck = stim[0];
            for (int k = 0; k < n; k++) begin
                exp_wa.push_back(5'(k));
                exp_wd.push_back({stim[4*k+4], stim[4*k+3], stim[4*k+2], stim[4*k+1]});
                for (int j = 1; j <= 4; j++) ck = ck ^ stim[4*k+j];
            end
            exp_ok = (stim[4*n+1] == ck);
            for (int k = 0; k < n; k++) exp_mem[exp_wa[k]] = exp_wd[k];
        end
    endtask

    // Offer stim bytes; mode 0 = always valid, 1 = valid every other cycle, 2 = random gaps.
    task automatic send_stim(input int mode, input int start_at);
        int  i;
        int  cyc;
        bit  gap;
        i   = 0;
        cyc = 0;
        while (i < stim.size() && cyc < 64 + 8 * stim.size()) begin
            @(negedge clk);
            cyc++;
            start = (start_at >= 0 && cyc == start_at);
            if (mode == 1)      gap = (cyc % 2 == 0);
            else if (mode == 2) gap = ($urandom_range(0, 2) == 0);
            else                gap = 1'b0;
            if (gap) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
            end else begin
                in_valid = 1'b1;
                in_data  = stim[i];
                if (in_ready) i++;
            end
        end
        chk("stream_drained", 32'(i), 32'(stim.size()));
    endtask

    // Full load: start, stream, then check final state, write log and memory image.
    task automatic run_load(input string tag, input int mode, input int start_at);
        int nw0;
        @(negedge clk);
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk_outs({tag, ".entry"}, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nw0 = log_addr.size();
        model_load();
        send_stim(mode, start_at);
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
        #1;
        chk_outs({tag, ".final"}, 1'b0, 1'b0, exp_ok, !exp_ok, exp_ok);
        chk({tag, ".nwrites"}, 32'(log_addr.size() - nw0), 32'(exp_wa.size()));
        for (int k = 0; k < exp_wa.size() && nw0 + k < log_addr.size(); k++) begin
            chk({tag, ".waddr"}, 32'(log_addr[nw0+k]), 32'(exp_wa[k]));
            chk({tag, ".wdata"}, log_data[nw0+k], exp_wd[k]);
        end
        for (int a = 0; a < 32; a++) chk({tag, ".mem"}, dut_mem[a], exp_mem[a]);
    endtask

    // Build a random load; N may exceed the depth, checksum is sometimes corrupted.
    task automatic build_random(input int sel);
        int  n;
        u8_t ck;
        u8_t b;
        stim.delete();
        if (sel == 0)      n = 0;
        else if (sel == 1) n = 32;
        else if (sel == 2) n = $urandom_range(33, 255);
        else               n = $urandom_range(1, 32);
        stim.push_back(u8_t'(n));
        if (n <= 32) begin
            ck = u8_t'(n);
            for (int j = 0; j < 4 * n; j++) begin
                b = u8_t'($urandom);
                stim.push_back(b);
                ck = ck ^ b;
            end
            if ($urandom_range(0, 3) == 0) ck = ck ^ u8_t'($urandom_range(1, 255));
            stim.push_back(ck);
        end
    endtask

    initial begin
        for (int a = 0; a < 32; a++) begin
            dut_mem[a] = 32'h0;
            exp_mem[a] = 32'h0;
        end
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.wr_en", 32'(wr_en), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Example program, good checksum.
        stim = '{8'h02, 8'h13, 8'h01, 8'hF0, 8'hFF, 8'h33, 8'h02, 8'h21, 8'h00, 8'h0F};
        run_load("t2", 0, -1);
        chk("t2.mem0", dut_mem[0], 32'hFFF00113);
        chk("t2.mem1", dut_mem[1], 32'h00210233);

        // Same program, bad checksum: writes still happen, load fails.
        stim = '{8'h02, 8'h13, 8'h01, 8'hF0, 8'hFF, 8'h33, 8'h02, 8'h21, 8'h00, 8'h00};
        run_load("t3", 0, -1);
        chk("t3.error", 32'(error), 32'd1);

        // Count above depth.
        stim = '{8'h21};
        run_load("t4", 0, -1);
        repeat (2) @(negedge clk);
        #1;
        chk("t4.in_ready_after", 32'(in_ready), 32'd0);

        // Gapped valid with a start pulse mid-load.
        stim = '{8'h02, 8'h13, 8'h01, 8'hF0, 8'hFF, 8'h33, 8'h02, 8'h21, 8'h00, 8'h0F};
        run_load("t5", 1, 7);
        chk("t5.mem0", dut_mem[0], 32'hFFF00113);
        chk("t5.mem1", dut_mem[1], 32'h00210233);

        // Reset asserted mid-cycle after byte 2 of word 1.
        begin
            int nw0;
            dut_mem[1] = 32'hDEADBEEF;
            exp_mem[1] = 32'hDEADBEEF;
            stim = '{8'h02, 8'h13, 8'h01, 8'hF0, 8'hFF, 8'h33, 8'h02};
            @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            nw0 = log_addr.size();
            send_stim(0, -1);
            @(posedge clk);
            #3;
            rst = 1'b0;
            #1;
            chk_outs("t1.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("t1.async.wr_en", 32'(wr_en), 32'd0);
            in_valid = 1'b0;
            repeat (3) @(negedge clk);
            chk("t6.nwrites", 32'(log_addr.size() - nw0), 32'd1);
            exp_mem[0] = 32'hFFF00113;
            chk("t6.mem0_pre", dut_mem[0], 32'hFFF00113);
            chk("t6.mem1_kept", dut_mem[1], 32'hDEADBEEF);
            rst = 1'b1;
        end
        stim = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
        run_load("t6", 0, -1);
        chk("t6.mem0", dut_mem[0], 32'h00000000);
        chk("t6.done", 32'(done), 32'd1);

        // Randomized loads back to back, starting from whatever state the last one left.
        for (int r = 0; r < 12; r++) begin
            build_random(r);
            run_load("rand", r % 3, ($urandom_range(0, 1) == 1) ? int'($urandom_range(4, 20)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
